// File: rtl/signed_sub_with_saturation_pipe.sv
// Two-stage valid/ready pipeline computing a saturating signed difference a - b,
// with a saturating count of clamped results handed to the consumer.
module signed_sub_with_saturation_pipe #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] diff,
    output logic             sat,
    output logic [CNT_W-1:0] sat_cnt,
    input  logic             sat_cnt_clr
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_diff;
    logic             r_s2_sat;

    logic [CNT_W-1:0] r_sat_cnt;

    logic             w_up_xfer;
    logic             w_down_xfer;
    logic             w_s2_load;

    logic [WIDTH:0]   w_a_ext;
    logic [WIDTH:0]   w_b_ext;
    logic [WIDTH:0]   w_raw;
    logic             w_ovf;
    logic [WIDTH-1:0] w_diff;

    assign up_ready    = !r_s1_valid || !r_s2_valid || down_ready;
    assign w_up_xfer   = up_valid && up_ready;
    assign w_down_xfer = r_s2_valid && down_ready;
    assign w_s2_load   = r_s1_valid && (!r_s2_valid || down_ready);

    assign w_a_ext = {r_s1_a[WIDTH-1], r_s1_a};
    assign w_b_ext = {r_s1_b[WIDTH-1], r_s1_b};
    assign w_raw   = w_a_ext - w_b_ext;
    assign w_ovf   = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &&
                     (w_raw[WIDTH-1] != r_s1_a[WIDTH-1]);

    // On overflow the exact sign bit w_raw[WIDTH] equals the sign of a.
    always_comb begin
        w_diff = w_raw[WIDTH-1:0];
        if (w_ovf) begin
            w_diff = w_raw[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_up_xfer) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= a;
            r_s1_b     <= b;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_diff  <= '0;
            r_s2_sat   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_s2_diff  <= w_diff;
            r_s2_sat   <= w_ovf;
        end else if (w_down_xfer) begin
            r_s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_cnt <= '0;
        end else if (sat_cnt_clr) begin
            r_sat_cnt <= '0;
        end else if (w_down_xfer && r_s2_sat && (r_sat_cnt != '1)) begin
            r_sat_cnt <= r_sat_cnt + CNT_W'(1);
        end
    end

    assign down_valid = r_s2_valid;
    assign diff       = r_s2_diff;
    assign sat        = r_s2_sat;
    assign sat_cnt    = r_sat_cnt;

endmodule

// File: tb/tb_signed_sub_with_saturation_pipe.sv
// Bench for signed_sub_with_saturation_pipe: directed and random traffic checked
// against an in-order queue model with plain integer clamp arithmetic.
module tb_signed_sub_with_saturation_pipe;

    localparam int W    = 4;
    localparam int CW   = 2;
    localparam int MAXP = (1 << (W - 1)) - 1;
    localparam int MINN = -(1 << (W - 1));
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          up_valid = 1'b0;
    logic          up_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          down_valid;
    logic          down_ready = 1'b0;
    logic [W-1:0]  diff;
    logic          sat;
    logic [CW-1:0] sat_cnt;
    logic          sat_cnt_clr = 1'b0;

    signed_sub_with_saturation_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .up_valid(up_valid), .up_ready(up_ready), .a(a), .b(b),
        .down_valid(down_valid), .down_ready(down_ready),
        .diff(diff), .sat(sat),
        .sat_cnt(sat_cnt), .sat_cnt_clr(sat_cnt_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           e;
        logic [W-1:0] d;
        logic         s;
    } item_t;

    item_t q[$];
    int    edges  = 0;
    int    cnt    = 0;
    int    total  = 0;
    int    passed = 0;
    int    fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic item_t ref_sub(input logic [W-1:0] ia, input logic [W-1:0] ib);
        item_t r;
        int    sa;
        int    sb;
        int    d;
        sa = $signed(ia);
        sb = $signed(ib);
        d  = sa - sb;
        r.e = 0;
        r.s = 1'b0;
        if (d > MAXP) begin
            d = MAXP;
            r.s = 1'b1;
        end else if (d < MINN) begin
            d = MINN;
            r.s = 1'b1;
        end
        r.d = d[W-1:0];
        return r;
    endfunction

    // One clock of traffic; handshake outcomes come from the model, not the DUT.
    task automatic cycle(input logic uv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic dr, input logic clr, output logic uxfer);
        logic  exp_ur;
        logic  exp_dv;
        logic  dxfer;
        logic  s;
        item_t it;
        @(negedge clk);
        up_valid    = uv;
        a           = ia;
        b           = ib;
        down_ready  = dr;
        sat_cnt_clr = clr;
        #1;
        exp_ur = (q.size() < 2) || dr;
        exp_dv = (q.size() > 0) && (edges >= q[0].e + 1);
        chk("up_ready", up_ready, exp_ur);
        chk("down_valid", down_valid, exp_dv);
        if (exp_dv) begin
            chk("diff", diff, q[0].d);
            chk("sat", sat, q[0].s);
        end
        dxfer = exp_dv && dr;
        uxfer = uv && exp_ur;
        @(posedge clk);
        edges++;
        s = 1'b0;
        if (dxfer) begin
            it = q.pop_front();
            s  = it.s;
        end
        if (clr) cnt = 0;
        else if (dxfer && s && cnt < CMAX) cnt++;
        if (uxfer) begin
            it   = ref_sub(ia, ib);
            it.e = edges;
            q.push_back(it);
        end
        #1;
        chk("sat_cnt", sat_cnt, cnt);
    endtask

    task automatic idle(input int n);
        logic ux;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, ux);
    endtask

    task automatic check_reset_state();
        chk("rst_down_valid", down_valid, 1'b0);
        chk("rst_up_ready", up_ready, 1'b1);
        chk("rst_diff", diff, '0);
        chk("rst_sat", sat, 1'b0);
        chk("rst_sat_cnt", sat_cnt, '0);
    endtask

    logic [W-1:0] pa [4];
    logic [W-1:0] pb [4];
    logic         ux;
    int           idx;
    int           guard;
    logic         pend_v;
    logic [W-1:0] pend_a;
    logic [W-1:0] pend_b;

    initial begin
        // Reset state
        #1;
        check_reset_state();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic difference: 3 - 5 = -2
        cycle(1'b1, 4'd3, 4'd5, 1'b1, 1'b0, ux);
        idle(3);

        // Saturation both directions, counter reaches 2
        cycle(1'b1, 4'b1000, 4'd1, 1'b1, 1'b0, ux);
        cycle(1'b1, 4'd7, 4'hF, 1'b1, 1'b0, ux);
        idle(3);
        chk("sat_cnt_two", sat_cnt, 2);

        // Edge operands
        cycle(1'b1, 4'b1000, 4'b1000, 1'b1, 1'b0, ux);
        cycle(1'b1, 4'd0, 4'b1000, 1'b1, 1'b0, ux);
        cycle(1'b1, 4'hF, 4'd7, 1'b1, 1'b0, ux);
        idle(3);

        // Backpressure: four pairs, consumer stalled for 5 cycles
        cycle(1'b0, '0, '0, 1'b1, 1'b1, ux);
        pa[0] = 4'd1; pb[0] = 4'd2;
        pa[1] = 4'd6; pb[1] = 4'hE;
        pa[2] = 4'hC; pb[2] = 4'd3;
        pa[3] = 4'd5; pb[3] = 4'd5;
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(idx < 4, pa[idx % 4], pb[idx % 4], 1'b0, 1'b0, ux);
            if (ux) idx++;
        end
        chk("bp_accepted", idx, 2);
        guard = 0;
        while ((idx < 4 || q.size() > 0) && guard < 20) begin
            cycle(idx < 4, pa[idx % 4], pb[idx % 4], 1'b1, 1'b0, ux);
            if (ux) idx++;
            guard++;
        end
        chk("bp_drained", guard < 20, 1'b1);

        // Counter saturates at all-ones
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'd0, 4'b1000, 1'b1, 1'b0, ux);
        idle(3);
        chk("cnt_saturated", sat_cnt, CMAX);

        // Clear coincident with a saturating transfer
        cycle(1'b1, 4'd0, 4'b1000, 1'b0, 1'b0, ux);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, ux);
        cycle(1'b0, '0, '0, 1'b1, 1'b1, ux);
        chk("clr_wins", sat_cnt, 0);
        idle(2);

        // Reset with both stages full
        cycle(1'b1, 4'd1, 4'd2, 1'b0, 1'b0, ux);
        cycle(1'b1, 4'd2, 4'd5, 1'b0, 1'b0, ux);
        cycle(1'b1, 4'd4, 4'd5, 1'b0, 1'b0, ux);
        @(negedge clk);
        up_valid = 1'b0;
        down_ready = 1'b0;
        sat_cnt_clr = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_reset_state();
        q.delete();
        cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 4'd6, 4'd2, 1'b1, 1'b0, ux);
        idle(3);

        // Random traffic with a producer that holds unaccepted operands
        pend_v = 1'b0;
        pend_a = '0;
        pend_b = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend_v && $urandom_range(0, 3) != 0) begin
                pend_v = 1'b1;
                pend_a = W'($urandom_range(0, 15));
                pend_b = W'($urandom_range(0, 15));
            end
            cycle(pend_v, pend_a, pend_b, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0, ux);
            if (ux) pend_v = 1'b0;
        end
        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0, ux);
            guard++;
        end
        chk("final_drain", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
